// File: rtl/sha256_pkg.sv
`default_nettype none
// ============================================================================
// sha256_pkg : shared state encoding and constants for the SHA-256 sequencer
// Revision   : 1.0
// ============================================================================
package sha256_pkg;

  localparam int unsigned SHA_ROUNDS    = 64;
  localparam int unsigned SHA_BLK_WORDS = 16;
  localparam int unsigned SHA_WORD_W    = 32;
  localparam int unsigned SHA_DIGEST_W  = 256;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_ISSUE = 3'd2,
    ST_WAIT  = 3'd3,
    ST_OUT   = 3'd4
  } seq_state_t;

endpackage
`default_nettype wire

// File: rtl/sha256_seq_buf.sv
`default_nettype none
// ============================================================================
// sha256_seq_buf : 16x32 block buffer, one sync write port, one comb read port
// Revision       : 1.0
// ============================================================================
module sha256_seq_buf
  import sha256_pkg::*;
(
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [3:0]            wr_addr,
  input  logic [SHA_WORD_W-1:0] wr_data,
  input  logic [5:0]            rd_cnt,
  output logic [SHA_WORD_W-1:0] rd_data
);

  logic [SHA_WORD_W-1:0] mem_q [SHA_BLK_WORDS];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  // Rounds 16..63 carry no message word; the core expands the schedule itself.
  always_comb begin
    rd_data = '0;
    if (rd_cnt[5:4] == 2'b00) begin
      rd_data = mem_q[rd_cnt[3:0]];
    end
  end

endmodule
`default_nettype wire

// File: rtl/sha256_main_seq.sv
`default_nettype none
// ============================================================================
// sha256_main_seq : buffers 512-bit blocks, replays them to the compression
//                   core over 64 rounds and returns the final digest
// Revision        : 1.0
// ============================================================================
module sha256_main_seq
  import sha256_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    m_valid,
  output logic                    m_ready,
  input  logic [SHA_WORD_W-1:0]   m_data,
  input  logic                    m_last,
  output logic                    w_vld,
  output logic [5:0]              w_cnt,
  output logic [SHA_WORD_W-1:0]   w_data,
  input  logic                    hash_done,
  input  logic [SHA_DIGEST_W-1:0] s_data,
  output logic                    dg_valid,
  input  logic                    dg_ready,
  output logic [SHA_DIGEST_W-1:0] dg_data,
  output logic                    busy,
  output logic                    err
);

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);
  localparam logic [5:0] RD_LAST  = 6'(SHA_ROUNDS - 1);
  localparam logic [3:0] WR_LAST  = 4'(SHA_BLK_WORDS - 1);

  seq_state_t              state_q, state_d;
  logic [3:0]              wr_idx_q, wr_idx_d;
  logic [5:0]              rd_cnt_q, rd_cnt_d;
  logic [7:0]              tmo_q, tmo_d;
  logic                    last_q, last_d;
  logic [SHA_DIGEST_W-1:0] dg_q, dg_d;
  logic                    err_q, err_d;
  logic                    wr_en;
  logic [SHA_WORD_W-1:0]   buf_rd;

  assign m_ready  = (state_q == ST_IDLE) || (state_q == ST_LOAD);
  assign wr_en    = m_valid && m_ready;
  assign w_vld    = (state_q == ST_ISSUE);
  assign w_cnt    = rd_cnt_q;
  assign w_data   = w_vld ? buf_rd : '0;
  assign dg_valid = (state_q == ST_OUT);
  assign dg_data  = dg_q;
  assign busy     = (state_q != ST_IDLE);
  assign err      = err_q;

  sha256_seq_buf u_buf (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_idx_q),
    .wr_data (m_data),
    .rd_cnt  (rd_cnt_q),
    .rd_data (buf_rd)
  );

  always_comb begin
    state_d  = state_q;
    wr_idx_d = wr_idx_q;
    rd_cnt_d = rd_cnt_q;
    tmo_d    = tmo_q;
    last_d   = last_q;
    dg_d     = dg_q;
    err_d    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (wr_en) begin
          wr_idx_d = 4'd1;
          state_d  = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (wr_en) begin
          if (wr_idx_q == WR_LAST) begin
            wr_idx_d = '0;
            last_d   = m_last;
            rd_cnt_d = '0;
            state_d  = ST_ISSUE;
          end else begin
            wr_idx_d = wr_idx_q + 4'd1;
          end
        end
      end
      ST_ISSUE: begin
        if (rd_cnt_q == RD_LAST) begin
          rd_cnt_d = '0;
          tmo_d    = '0;
          state_d  = ST_WAIT;
        end else begin
          rd_cnt_d = rd_cnt_q + 6'd1;
        end
      end
      ST_WAIT: begin
        if (hash_done) begin
          if (last_q) begin
            dg_d    = s_data;
            state_d = ST_OUT;
          end else begin
            // Chained block: the next 16 words refill the buffer from word 0.
            wr_idx_d = '0;
            state_d  = ST_LOAD;
          end
        end else if (tmo_q >= TMO_LAST) begin
          err_d    = 1'b1;
          wr_idx_d = '0;
          state_d  = ST_IDLE;
        end else begin
          tmo_d = (tmo_q == 8'hFF) ? tmo_q : tmo_q + 8'd1;
        end
      end
      ST_OUT: begin
        if (dg_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      wr_idx_q <= '0;
      rd_cnt_q <= '0;
      tmo_q    <= '0;
      last_q   <= 1'b0;
      dg_q     <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_idx_q <= wr_idx_d;
      rd_cnt_q <= rd_cnt_d;
      tmo_q    <= tmo_d;
      last_q   <= last_d;
      dg_q     <= dg_d;
      err_q    <= err_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sha256_main_seq.sv
`default_nettype none
// ============================================================================
// tb_sha256_main_seq : scoreboard bench for the SHA-256 block sequencer
// Revision           : 1.0
// ============================================================================
module tb_sha256_main_seq;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         m_valid = 1'b0;
  logic         m_ready;
  logic [31:0]  m_data = '0;
  logic         m_last = 1'b0;
  logic         w_vld;
  logic [5:0]   w_cnt;
  logic [31:0]  w_data;
  logic         hash_done;
  logic [255:0] s_data;
  logic         dg_valid;
  logic         dg_ready = 1'b1;
  logic [255:0] dg_data;
  logic         busy;
  logic         err;

  int total = 0;
  int bad   = 0;
  bit core_en = 1'b1;
  logic [255:0] exp_q [$];

  localparam logic [255:0] IV = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  localparam logic [255:0] DG_ABC = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] DG_2B  = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
  localparam logic [511:0] BLK_ABC = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] BLK_2A  = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                      32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                      32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                      32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
  localparam logic [511:0] BLK_2B  = {480'h0, 32'h000001c0};

  logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  sha256_main_seq #(.TIMEOUT(10)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .m_last    (m_last),
    .w_vld     (w_vld),
    .w_cnt     (w_cnt),
    .w_data    (w_data),
    .hash_done (hash_done),
    .s_data    (s_data),
    .dg_valid  (dg_valid),
    .dg_ready  (dg_ready),
    .dg_data   (dg_data),
    .busy      (busy),
    .err       (err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Reference SHA-256 compression of one block, including the feed-forward add.
  function automatic logic [255:0] sha_comp(input logic [255:0] hin, input logic [511:0] blk);
    logic [31:0] w [64];
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2, s0, s1;
    for (int t = 0; t < 16; t++) w[t] = blk[511 - 32*t -: 32];
    for (int t = 16; t < 64; t++) begin
      s0 = ror(w[t-15], 7) ^ ror(w[t-15], 18) ^ (w[t-15] >> 3);
      s1 = ror(w[t-2], 17) ^ ror(w[t-2], 19) ^ (w[t-2] >> 10);
      w[t] = s1 + w[t-7] + s0 + w[t-16];
    end
    {a, b, c, d, e, f, g, h} = hin;
    for (int t = 0; t < 64; t++) begin
      t1 = h + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + K[t] + w[t];
      t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
      h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
    end
    return {hin[255:224] + a, hin[223:192] + b, hin[191:160] + c, hin[159:128] + d,
            hin[127:96] + e, hin[95:64] + f, hin[63:32] + g, hin[31:0] + h};
  endfunction

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic put_word(input logic [31:0] d, input logic l);
    int n = 0;
    m_valid = 1'b1;
    m_data  = d;
    m_last  = l;
    while (!m_ready && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 400) check("put_word_wait", 0, 1);
    @(posedge clk); #1;
  endtask

  task automatic send_block(input logic [511:0] blk, input logic last, input bit gaps, input bit hold);
    int n = 0;
    for (int i = 0; i < 16; i++) begin
      if (gaps && i > 0) begin
        m_valid = 1'b0;
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      end
      put_word(blk[511 - 32*i -: 32], (i == 15) ? last : 1'($urandom_range(0, 1)));
    end
    if (hold) begin
      m_data = 32'hdeadbeef;
      while (!dg_valid && n < 400) begin @(posedge clk); #1; n++; end
      check("hold_wait_dg", (n < 400), 1);
    end
    m_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 2000) begin @(posedge clk); #1; n++; end
    check("drain", (n < 2000), 1);
  endtask

  initial begin : core_model
    logic [511:0] blk;
    logic [255:0] h, pend;
    int cd;
    hash_done = 1'b0;
    s_data = '0;
    h = IV;
    pend = '0;
    blk = '0;
    cd = 0;
    forever begin
      @(posedge clk); #1;
      hash_done = 1'b0;
      if (!reset_n) begin
        h = IV;
        cd = 0;
        continue;
      end
      if (dg_valid && dg_ready) h = IV;
      if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          hash_done = 1'b1;
          s_data = pend;
          h = pend;
        end
      end
      if (w_vld) begin
        if (w_cnt < 6'd16) blk[511 - 32*int'(w_cnt) -: 32] = w_data;
        if (w_cnt == 6'd63 && core_en) begin
          pend = sha_comp(h, blk);
          cd = 3;
        end
      end
    end
  end

  initial begin : monitor
    int run_len = 0;
    int acc = 0;
    logic pv = 1'b0;
    logic pr = 1'b0;
    logic [255:0] pd = '0;
    logic [255:0] e;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        run_len = 0;
        acc = 0;
        pv = 1'b0;
        continue;
      end
      if (m_valid && m_ready) acc++;
      if (w_vld) begin
        check("m_ready_in_issue", m_ready, 0);
        check("w_cnt_seq", w_cnt, run_len);
        if (w_cnt >= 6'd16) check("w_data_zero", w_data, 0);
        if (run_len == 0) begin
          check("words_per_block", acc, 16);
          acc = 0;
        end
        run_len++;
      end else if (run_len != 0) begin
        check("issue_len", run_len, 64);
        run_len = 0;
      end
      if (dg_valid) begin
        check("m_ready_in_out", m_ready, 0);
        if (!pv) check("no_accept_in_wait", acc, 0);
        if (dg_ready) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_digest: got %h want none", dg_data);
          end else begin
            e = exp_q.pop_front();
            check("digest", dg_data, e);
          end
        end
      end
      if (pv && !pr) begin
        check("dg_valid_hold", dg_valid, 1);
        check("dg_data_hold", dg_data, pd);
      end
      pv = dg_valid;
      pr = dg_ready;
      pd = dg_data;
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin : stim
    int n;
    repeat (3) @(posedge clk);
    #1;
    check("rst_m_ready", m_ready, 1);
    check("rst_w_vld", w_vld, 0);
    check("rst_w_cnt", w_cnt, 0);
    check("rst_w_data", w_data, 0);
    check("rst_dg_valid", dg_valid, 0);
    check("rst_dg_data", dg_data, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Single block "abc"
    exp_q.push_back(DG_ABC);
    send_block(BLK_ABC, 1'b1, 1'b0, 1'b0);
    wait_drain();

    // Two-block message
    exp_q.push_back(DG_2B);
    send_block(BLK_2A, 1'b0, 1'b0, 1'b0);
    send_block(BLK_2B, 1'b1, 1'b0, 1'b0);
    wait_drain();

    // Input gaps, m_valid held high through ISSUE/WAIT
    exp_q.push_back(DG_ABC);
    send_block(BLK_ABC, 1'b1, 1'b1, 1'b1);
    wait_drain();

    // Digest backpressure
    dg_ready = 1'b0;
    exp_q.push_back(DG_2B);
    send_block(BLK_2A, 1'b0, 1'b1, 1'b0);
    send_block(BLK_2B, 1'b1, 1'b1, 1'b0);
    n = 0;
    while (!dg_valid && n < 400) begin @(posedge clk); #1; n++; end
    check("bp_wait_dg", (n < 400), 1);
    m_valid = 1'b1;
    repeat (20) begin
      @(posedge clk); #1;
      check("bp_dg_valid", dg_valid, 1);
      check("bp_m_ready", m_ready, 0);
    end
    m_valid = 1'b0;
    dg_ready = 1'b1;
    wait_drain();

    // Timeout with a silent core
    core_en = 1'b0;
    send_block(BLK_ABC, 1'b1, 1'b0, 1'b0);
    n = 0;
    while (w_vld && n < 100) begin @(posedge clk); #1; n++; end
    n = 0;
    while (!err && n < 40) begin @(posedge clk); #1; n++; end
    check("tmo_cycles", n, 10);
    check("tmo_busy", busy, 0);
    check("tmo_m_ready", m_ready, 1);
    @(posedge clk); #1;
    check("tmo_err_pulse", err, 0);
    core_en = 1'b1;

    // Reset in the middle of ISSUE, then a clean block
    send_block(BLK_ABC, 1'b1, 1'b0, 1'b0);
    n = 0;
    while (!(w_vld && w_cnt == 6'd30) && n < 100) begin @(posedge clk); #1; n++; end
    check("rst_wait_w30", (n < 100), 1);
    #2;
    reset_n = 1'b0;
    #1;
    check("rst_mid_w_vld", w_vld, 0);
    check("rst_mid_busy", busy, 0);
    @(posedge clk);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    exp_q.push_back(DG_ABC);
    send_block(BLK_ABC, 1'b1, 1'b0, 1'b0);
    wait_drain();

    repeat (5) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
